icache_ctrl: RTL and testbench

Direct-mapped instruction cache controller that serves fetch-stage instruction requests. It answers each PC lookup in the same cycle on a hit. On a miss it stalls fetch, refills one line from the memory side over a request/ready handshake, and then resumes. It sits between the fetch stage (PC producer) and the instruction memory model, and is the responder to fetch's PC requests.

---
 rtl/icache_ctrl_pkg.sv | 24 ++
 rtl/icache_array.sv | 60 ++++++
 rtl/icache_ctrl.sv | 143 ++++++++++++++
 tb/tb_icache_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/icache_ctrl_pkg.sv
// Shared definitions for the instruction cache controller: address width,
// FSM state encodings and the address field widths of the default geometry.
package icache_ctrl_pkg;

  // Default address and instruction width in bits
  localparam int unsigned ICACHE_ADDR_SIZE = 32;
  localparam int unsigned WORD_BITS        = 32;
  // Byte-within-word bits, always ignored by the cache
  localparam int unsigned BYTE_BITS        = 2;

  // Default geometry and its derived field widths
  localparam int unsigned DEF_LINES        = 4;
  localparam int unsigned DEF_LINE_WORDS   = 4;
  localparam int unsigned DEF_OFFSET_BITS  = $clog2(DEF_LINE_WORDS);
  localparam int unsigned DEF_INDEX_BITS   = $clog2(DEF_LINES);
  localparam int unsigned DEF_TAG_BITS     = ICACHE_ADDR_SIZE - BYTE_BITS
                                             - DEF_OFFSET_BITS - DEF_INDEX_BITS;

  typedef enum logic {
    ICACHE_LOOKUP = 1'b0,
    ICACHE_REFILL = 1'b1
  } icache_state_e;

endpackage

// File: rtl/icache_array.sv
// Register-based storage for the direct-mapped cache: per-line valid bit,
// tag and data. Combinational read port, one line-write port, global clear.
//   clk, reset     : clock, synchronous active-high reset (clears valid only)
//   clear          : invalidate every line at the edge
//   wr_en/index/tag/line : install a line; wins over clear for its own index
//   rd_index       : line to read
//   rd_valid_c/rd_tag_c/rd_line_c : combinational read data
module icache_array
  import icache_ctrl_pkg::*;
#(
  parameter int unsigned LINES      = DEF_LINES,
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
  parameter int unsigned TAG_BITS   = DEF_TAG_BITS
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clear,
  input  logic                            wr_en,
  input  logic [$clog2(LINES)-1:0]        wr_index,
  input  logic [TAG_BITS-1:0]             wr_tag,
  input  logic [WORD_BITS*LINE_WORDS-1:0] wr_line,
  input  logic [$clog2(LINES)-1:0]        rd_index,
  output logic                            rd_valid_c,
  output logic [TAG_BITS-1:0]             rd_tag_c,
  output logic [WORD_BITS*LINE_WORDS-1:0] rd_line_c
);

  localparam int unsigned LINE_BITS = WORD_BITS * LINE_WORDS;

  logic [LINES-1:0]     valid_q;
  logic [TAG_BITS-1:0]  tag_q  [LINES];
  logic [LINE_BITS-1:0] data_q [LINES];

  // Valid bits: clear first, so a same-edge install survives for its index
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      if (clear) begin
        valid_q <= '0;
      end
      if (wr_en) begin
        valid_q[wr_index] <= 1'b1;
      end
    end
  end

  // Tag and data are never reset; valid gates their use
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_line;
    end
  end

  assign rd_valid_c = valid_q[rd_index];
  assign rd_tag_c   = tag_q[rd_index];
  assign rd_line_c  = data_q[rd_index];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller. Hits answer in the same cycle;
// a miss stalls fetch and refills one line over a level-based req/ready
// handshake, then the held PC hits on the return to LOOKUP.
//   clk, reset            : clock, synchronous active-high reset
//   req_valid, req_addr   : fetch PC request (bits [1:0] ignored)
//   flush                 : invalidate all lines (in-flight refill still installs)
//   resp_valid, resp_data : combinational hit response
//   stall                 : fetch must hold PC and IF/ID
//   mem_req, mem_addr     : line refill request, line-aligned address
//   mem_ready, mem_line   : refill completion and line data (word 0 in LSBs)
module icache_ctrl
  import icache_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_SIZE  = ICACHE_ADDR_SIZE,
  parameter int unsigned LINES      = DEF_LINES,
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            req_valid,
  input  logic [ADDR_SIZE-1:0]            req_addr,
  input  logic                            flush,
  output logic                            resp_valid,
  output logic [ADDR_SIZE-1:0]            resp_data,
  output logic                            stall,
  output logic                            mem_req,
  output logic [ADDR_SIZE-1:0]            mem_addr,
  input  logic                            mem_ready,
  input  logic [WORD_BITS*LINE_WORDS-1:0] mem_line
);

  localparam int unsigned OFF_BITS  = $clog2(LINE_WORDS);
  localparam int unsigned IDX_BITS  = $clog2(LINES);
  localparam int unsigned IDX_LSB   = BYTE_BITS + OFF_BITS;
  localparam int unsigned TAG_LSB   = IDX_LSB + IDX_BITS;
  localparam int unsigned TAG_BITS  = ADDR_SIZE - TAG_LSB;
  localparam int unsigned LINE_BITS = WORD_BITS * LINE_WORDS;

  icache_state_e          state_q, state_d;
  logic [ADDR_SIZE-1:0]   miss_addr_q, miss_addr_d;

  logic [OFF_BITS-1:0]    req_word;
  logic [IDX_BITS-1:0]    req_index;
  logic [TAG_BITS-1:0]    req_tag;
  logic                   rd_valid_c;
  logic [TAG_BITS-1:0]    rd_tag_c;
  logic [LINE_BITS-1:0]   rd_line_c;
  logic [WORD_BITS-1:0]   words_c [LINE_WORDS];
  logic [WORD_BITS-1:0]   sel_word_c;
  logic                   lookup_hit_c;
  logic                   wr_en_c;
  logic                   unused_byte_bits;

  assign req_word         = req_addr[BYTE_BITS +: OFF_BITS];
  assign req_index        = req_addr[IDX_LSB +: IDX_BITS];
  assign req_tag          = req_addr[ADDR_SIZE-1:TAG_LSB];
  assign unused_byte_bits = ^req_addr[BYTE_BITS-1:0];

  // Storage array, read by the request index, written from the latched miss
  icache_array #(
    .LINES      (LINES),
    .LINE_WORDS (LINE_WORDS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk        (clk),
    .reset      (reset),
    .clear      (flush),
    .wr_en      (wr_en_c),
    .wr_index   (miss_addr_q[IDX_LSB +: IDX_BITS]),
    .wr_tag     (miss_addr_q[ADDR_SIZE-1:TAG_LSB]),
    .wr_line    (mem_line),
    .rd_index   (req_index),
    .rd_valid_c (rd_valid_c),
    .rd_tag_c   (rd_tag_c),
    .rd_line_c  (rd_line_c)
  );

  // Word select within the read line
  always_comb begin
    for (int unsigned i = 0; i < LINE_WORDS; i++) begin
      words_c[i] = rd_line_c[WORD_BITS*i +: WORD_BITS];
    end
    sel_word_c = words_c[req_word];
  end

  assign lookup_hit_c = req_valid && rd_valid_c && (rd_tag_c == req_tag);
  // Refill install; a reset in the same cycle discards it
  assign wr_en_c      = (state_q == ICACHE_REFILL) && mem_ready && !reset;

  // State and latched miss address
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ICACHE_LOOKUP;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    case (state_q)
      ICACHE_LOOKUP: begin
        if (req_valid && !lookup_hit_c) begin
          state_d     = ICACHE_REFILL;
          miss_addr_d = {req_addr[ADDR_SIZE-1:IDX_LSB], {IDX_LSB{1'b0}}};
        end
      end
      ICACHE_REFILL: begin
        if (mem_ready) begin
          state_d = ICACHE_LOOKUP;
        end
      end
      default: state_d = ICACHE_LOOKUP;
    endcase
  end

  // Outputs: hit response in LOOKUP, held request in REFILL
  always_comb begin
    resp_valid = 1'b0;
    resp_data  = '0;
    stall      = 1'b0;
    mem_req    = 1'b0;
    mem_addr   = '0;
    case (state_q)
      ICACHE_LOOKUP: begin
        resp_valid = lookup_hit_c;
        resp_data  = lookup_hit_c ? ADDR_SIZE'(sel_word_c) : '0;
        stall      = req_valid && !lookup_hit_c;
      end
      ICACHE_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = miss_addr_q;
        stall    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Scoreboard bench for icache_ctrl: fetch stimulus pushes the expected
// instruction; a negedge monitor pops it whenever resp_valid is seen.
// The reference is an index/tag occupancy model computed with arithmetic.
module tb_icache_ctrl;

  localparam int unsigned LINES = 4;
  localparam int unsigned LW    = 4;
  localparam int unsigned LBYTES = 4 * LW;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid;
  logic [31:0]     req_addr;
  logic            flush;
  logic            resp_valid;
  logic [31:0]     resp_data;
  logic            stall;
  logic            mem_req;
  logic [31:0]     mem_addr;
  logic            mem_ready;
  logic [32*LW-1:0] mem_line;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  bit          vm [LINES];
  logic [31:0] tm [LINES];
  int          lat  = 0;
  bit          hold = 1'b0;
  int          cnt  = 0;

  always #5 clk = ~clk;

  icache_ctrl #(.ADDR_SIZE(32), .LINES(LINES), .LINE_WORDS(LW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .flush(flush), .resp_valid(resp_valid), .resp_data(resp_data),
    .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_line(mem_line)
  );

  // Instruction memory contents; line 0 holds 0x11,0x22,0x33,0x44
  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] a2;
    a2 = {a[31:2], 2'b00};
    if (a2[31:4] == 28'd0) return (32'(a2[3:2]) + 32'd1) * 32'h11;
    return (a2 * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [32*LW-1:0] line_of(input logic [31:0] base);
    logic [32*LW-1:0] l;
    for (int i = 0; i < LW; i++) l[32*i +: 32] = word_at(base + 32'(4*i));
    return l;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: fixed latency after mem_req, or ready held high
  always @(negedge clk) begin
    if (mem_req) begin
      mem_line = line_of(mem_addr);
      if (hold || cnt >= lat) mem_ready = 1'b1;
      else begin
        mem_ready = 1'b0;
        cnt++;
      end
    end else begin
      cnt = 0;
      mem_ready = hold;
    end
  end

  // Monitor: every response must match the oldest expected instruction
  always @(negedge clk) begin
    if (!reset && resp_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got %h with no pending fetch", resp_data);
      end else begin
        chk("resp_data", resp_data, exp_q.pop_front());
      end
    end
  end

  task automatic clear_model();
    for (int i = 0; i < LINES; i++) vm[i] = 1'b0;
  endtask

  task automatic idle_check();
    req_valid = 1'b0;
    @(negedge clk);
    chk("idle_resp_valid", resp_valid, 0);
    chk("idle_stall", stall, 0);
    chk("idle_mem_req", mem_req, 0);
    chk("idle_mem_addr", mem_addr, 0);
    chk("idle_resp_data", resp_data, 0);
    @(posedge clk); #1;
  endtask

  // One fetch held until it is answered; flush_at<0 means no flush
  task automatic fetch(input logic [31:0] a, input int flush_at);
    logic [31:0] blk, tg, la;
    int idx, exp_stall, exp_mreq, k, st, mr;
    bit hit, done, fl, late;
    blk = a / LBYTES;
    idx = int'(blk % LINES);
    tg  = blk / LINES;
    la  = blk * LBYTES;
    hit = vm[idx] && (tm[idx] == tg);
    exp_stall = hit ? 0 : 2 + (hold ? 0 : lat);
    exp_mreq  = hit ? 0 : 1 + (hold ? 0 : lat);
    exp_q.push_back(word_at(a));
    req_valid = 1'b1;
    req_addr  = a;
    k = 0; st = 0; mr = 0; done = 1'b0;
    while (!done && k < 64) begin
      flush = (k == flush_at);
      @(negedge clk);
      if (resp_valid) begin
        done = 1'b1;
        chk("hit_stall", stall, 0);
      end else begin
        st++;
        chk("miss_stall", stall, 1);
        chk("miss_resp_data", resp_data, 0);
      end
      if (mem_req) begin
        mr++;
        chk("mem_addr", mem_addr, la);
      end
      @(posedge clk); #1;
      k++;
    end
    flush = 1'b0;
    req_valid = 1'b0;
    chk("resp_seen", 32'(done), 1);
    chk("stall_cycles", st, exp_stall);
    chk("mem_req_cycles", mr, exp_mreq);
    // Flush in the answering cycle of a miss lands after the install
    fl   = (flush_at >= 0) && (flush_at < k);
    late = fl && !hit && done && (flush_at == k - 1);
    if (fl && !late) clear_model();
    if (!hit) begin
      vm[idx] = 1'b1;
      tm[idx] = tg;
    end
    if (late) clear_model();
  endtask

  // Reset pulse two cycles into a refill
  task automatic reset_mid(input logic [31:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_mem_req", mem_req, 0);
    chk("rst_mid_stall", stall, 0);
    chk("rst_mid_resp_valid", resp_valid, 0);
    clear_model();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] a;
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
    mem_ready = 1'b0; mem_line = '0;
    clear_model();
    for (int i = 0; i < LINES; i++) tm[i] = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle_check();

    // Cold start, then same-line hits
    lat = 3;
    fetch(32'h0000_0000, -1);
    fetch(32'h0000_0004, -1);
    fetch(32'h0000_0008, -1);
    fetch(32'h0000_000C, -1);
    // Conflict eviction on index 0
    fetch(32'h0000_0040, -1);
    fetch(32'h0000_0000, -1);
    // Zero-latency memory
    hold = 1'b1;
    fetch(32'h0000_0080, -1);
    fetch(32'h0000_00C4, -1);
    hold = 1'b0;
    idle_check();
    // Flush during refill: in-flight line survives, others are lost
    lat = 3;
    fetch(32'h0000_0010, -1);
    fetch(32'h0000_0100, 2);
    fetch(32'h0000_0104, -1);
    fetch(32'h0000_0010, -1);
    fetch(32'h0000_0000, -1);
    // Flush together with mem_ready (lat=1 completes at T+2)
    lat = 1;
    fetch(32'h0000_0020, -1);
    fetch(32'h0000_0130, 2);
    fetch(32'h0000_0134, -1);
    fetch(32'h0000_0020, -1);
    // Reset in the middle of a refill
    lat = 5;
    reset_mid(32'h0000_0100);
    idle_check();
    fetch(32'h0000_0100, -1);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      lat  = $urandom_range(0, 3);
      hold = ($urandom_range(0, 3) == 0);
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 4) == 0) a = a | 32'hFFFF_0000;
      fetch(a, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1);
      if ($urandom_range(0, 5) == 0) begin
        hold = 1'b0;
        idle_check();
      end
    end
    hold = 1'b0;
    idle_check();
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
